// File: rtl/mem_port_arbiter.sv
// Two-port (ifetch/data) round-robin arbiter onto a single memory port.
// Optional read timeout abort enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int MEM_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ifetch_req,
  input  logic [31:0]        ifetch_addr,
  output logic               ifetch_gnt,
  output logic               ifetch_rvalid,
  output logic [31:0]        ifetch_rdata,
  input  logic               data_req,
  input  logic               data_we,
  input  logic [31:0]        data_addr,
  input  logic [31:0]        data_wdata,
  input  logic [MEM_W/8-1:0] data_be,
  output logic               data_gnt,
  output logic               data_rvalid,
  output logic [31:0]        data_rdata,
  output logic               data_err,
  output logic               mem_access,
  output logic               mem_is_writing,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic [MEM_W/8-1:0] mem_be,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_out_valid,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_t;

  state_t      state;
  logic        last_data;
  logic        owner;
  logic        pick_i;
  logic        pick_d;
  logic        done_wr;
  logic        done_rd;
  logic        tmo;
  logic [31:0] rd_data;

  assign pick_i = (state == IDLE) && ifetch_req
                  && (!data_req || last_data);
  assign pick_d = (state == IDLE) && data_req && !pick_i;

  assign ifetch_gnt = !rst && pick_i;
  assign data_gnt   = !rst && pick_d;
  assign busy       = (state != IDLE);

  // mem_access marks the first BUSY cycle; completion is only
  // accepted from the second BUSY cycle on.
  assign done_wr = mem_is_writing && !mem_access;
  assign done_rd = !mem_is_writing && !mem_access && mem_out_valid;

  assign rd_data = tmo ? 32'hDEAD_BEEF : mem_rdata;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          err;

  assign tmo = (state == BUSY) && !mem_is_writing && !done_rd
               && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign data_err = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (state == BUSY) ? cnt + 1'b1 : '0;
      err <= tmo && owner;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign tmo        = 1'b0;
  assign data_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_data      <= 1'b1;
      owner          <= 1'b0;
      mem_access     <= 1'b0;
      mem_is_writing <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      ifetch_rvalid  <= 1'b0;
      ifetch_rdata   <= '0;
      data_rvalid    <= 1'b0;
      data_rdata     <= '0;
    end else begin
      mem_access    <= 1'b0;
      ifetch_rvalid <= 1'b0;
      data_rvalid   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_i || pick_d) begin
            state          <= BUSY;
            mem_access     <= 1'b1;
            owner          <= pick_d;
            last_data      <= pick_d;
            mem_is_writing <= pick_d && data_we;
            mem_addr       <= pick_d ? data_addr : ifetch_addr;
            mem_wdata      <= pick_d ? data_wdata : '0;
            mem_be         <= pick_d ? data_be : '1;
          end
        end
        BUSY: begin
          if (done_wr) begin
            state <= DRAIN;
          end else if (done_rd || tmo) begin
            state <= DRAIN;
            if (owner) begin
              data_rvalid <= 1'b1;
              data_rdata  <= rd_data;
            end else begin
              ifetch_rvalid <= 1'b1;
              ifetch_rdata  <= rd_data;
            end
          end
        end
        DRAIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, memory responder,
// read-response scoreboard and multi-cycle corner sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifetch_req;
  logic [31:0] ifetch_addr;
  logic        ifetch_gnt;
  logic        ifetch_rvalid;
  logic [31:0] ifetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        mem_access;
  logic        mem_is_writing;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_out_valid;
  logic        busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ifetch_req(ifetch_req),
    .ifetch_addr(ifetch_addr),
    .ifetch_gnt(ifetch_gnt),
    .ifetch_rvalid(ifetch_rvalid),
    .ifetch_rdata(ifetch_rdata),
    .data_req(data_req),
    .data_we(data_we),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_be(data_be),
    .data_gnt(data_gnt),
    .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .data_err(data_err),
    .mem_access(mem_access),
    .mem_is_writing(mem_is_writing),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .mem_rdata(mem_rdata),
    .mem_out_valid(mem_out_valid),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
  } vec_t;

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h100) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers reads lat_cfg cycles after mem_access.
  bit          resp_en = 1'b1;
  bit          poke    = 1'b0;
  int          lat_cfg = 1;
  int          resp_cnt = 0;
  logic [31:0] raddr;

  initial begin
    mem_out_valid = 1'b0;
    mem_rdata     = '0;
  end

  always @(negedge clk) begin
    mem_out_valid = poke;
    if (rst) begin
      resp_cnt = 0;
    end else if (resp_en && mem_access && !mem_is_writing) begin
      resp_cnt = lat_cfg;
      raddr    = mem_addr;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        mem_out_valid = 1'b1;
        mem_rdata     = mem_f(raddr);
      end
    end
  end

  // Response monitor against the scoreboard.
  always @(negedge clk) begin
    if (!rst && (ifetch_rvalid || data_rvalid)) begin
      checks++;
      if (ifetch_rvalid && data_rvalid) begin
        errors++;
        $display("FAIL dual_rvalid: both rvalid high");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_rvalid: i=%b d=%b, none expected",
                 ifetch_rvalid, data_rvalid);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.port != data_rvalid
            || (data_rvalid ? data_rdata : ifetch_rdata) !== mon_e.data
            || data_err !== mon_e.err) begin
          errors++;
          $display("FAIL resp: port=%b data=%h err=%b expected port=%b data=%h err=%b",
                   data_rvalid,
                   data_rvalid ? data_rdata : ifetch_rdata,
                   data_err, mon_e.port, mon_e.data, mon_e.err);
        end
      end
    end else if (!rst && data_err) begin
      checks++;
      errors++;
      $display("FAIL stray_err: data_err=1 expected 0");
    end
  end

  task automatic do_txn(input vec_t t, input bit push);
    int n;
    @(negedge clk);
    lat_cfg = t.lat;
    if (t.port) begin
      data_req   = 1'b1;
      data_we    = t.we;
      data_addr  = t.addr;
      data_wdata = t.wdata;
      data_be    = t.be;
    end else begin
      ifetch_req  = 1'b1;
      ifetch_addr = t.addr;
    end
    #1;
    chk("gnt", t.port ? data_gnt : ifetch_gnt, 1);
    chk("gnt_other", t.port ? ifetch_gnt : data_gnt, 0);
    if (push && !t.we) sb.push_back('{t.port, mem_f(t.addr), 1'b0});
    @(negedge clk);
    ifetch_req = 1'b0;
    data_req   = 1'b0;
    chk("access", mem_access, 1);
    chk("mem_addr", mem_addr, t.addr);
    chk("mem_be", mem_be, t.port ? t.be : 4'hF);
    chk("mem_we", mem_is_writing, t.we);
    if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
    n = 1;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
      if (t.we && n == 2) begin
        chk("access_1cyc", mem_access, 0);
        chk("wdata_hold", mem_wdata, t.wdata);
        chk("addr_hold", mem_addr, t.addr);
      end
    end
    chk("txn_len", n, t.we ? 4 : 3 + t.lat);
  endtask

  task automatic sim_drop;
    @(negedge clk);
    ifetch_req  = 1'b1;
    ifetch_addr = 32'h500;
    data_req    = 1'b1;
    data_we     = 1'b1;
    #1;
    chk("prio_i", ifetch_gnt, 1);
    chk("prio_d", data_gnt, 0);
    ifetch_req = 1'b0;
    data_req   = 1'b0;
    @(negedge clk);
    chk("drop_busy", busy, 0);
    chk("drop_access", mem_access, 0);
  endtask

  vec_t vecs[6];
  bit   order[4];
  int   ng;
  int   cyc;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 3};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'b0011, 0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF, 1};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0204, 32'h0, 4'hF, 5};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'b1000, 0};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'b0101, 2};

    rst = 1'b1;
    ifetch_req = 1'b0;
    ifetch_addr = '0;
    data_req = 1'b0;
    data_we = 1'b0;
    data_addr = '0;
    data_wdata = '0;
    data_be = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_access", mem_access, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_irdata", ifetch_rdata, 0);
    chk("rst_drdata", data_rdata, 0);
    chk("rst_err", data_err, 0);
    rst = 1'b0;

    sim_drop();

    for (int i = 0; i < 6; i++) do_txn(vecs[i], 1'b1);

    repeat (2) @(negedge clk);
    chk("ird_hold", ifetch_rdata, mem_f(32'h204));
    chk("drd_hold", data_rdata, mem_f(32'hFFFF_FFFC));

    // Both ports requesting continuously.
    @(negedge clk);
    lat_cfg     = 1;
    ifetch_req  = 1'b1;
    ifetch_addr = 32'h0000_0600;
    data_req    = 1'b1;
    data_we     = 1'b1;
    data_addr   = 32'h0000_0700;
    data_wdata  = 32'h0BAD_F00D;
    data_be     = 4'hF;
    ng  = 0;
    cyc = 0;
    while (ng < 4 && cyc < 80) begin
      #1;
      if (ifetch_gnt || data_gnt) begin
        order[ng] = data_gnt;
        if (ifetch_gnt) sb.push_back('{1'b0, mem_f(ifetch_addr), 1'b0});
        ng++;
      end
      @(negedge clk);
      cyc++;
    end
    ifetch_req = 1'b0;
    data_req   = 1'b0;
    chk("alt_count", ng, 4);
    for (int i = 0; i < 4; i++) chk("alt_order", order[i], i % 2);
    cyc = 0;
    while (busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("alt_idle", busy, 0);

    // mem_out_valid while idle.
    @(negedge clk);
    poke = 1'b1;
    repeat (2) @(negedge clk);
    poke = 1'b0;
    chk("idle_irv", ifetch_rvalid, 0);
    chk("idle_drv", data_rvalid, 0);
    @(negedge clk);
    chk("idle_irv2", ifetch_rvalid, 0);
    chk("idle_drv2", data_rvalid, 0);

    // Reset in the middle of a read.
    resp_en     = 1'b0;
    ifetch_req  = 1'b1;
    ifetch_addr = 32'h0000_0300;
    @(negedge clk);
    ifetch_req = 1'b0;
    chk("mid_access", mem_access, 1);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_irv", ifetch_rvalid, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_irdata", ifetch_rdata, 0);
    resp_en = 1'b1;
    sim_drop();
    do_txn('{1'b0, 1'b0, 32'h0000_0304, 32'h0, 4'hF, 2}, 1'b1);

`ifdef ARB_TIMEOUT_EN
    resp_en = 1'b0;
    sb.push_back('{1'b1, 32'hDEAD_BEEF, 1'b1});
    do_txn('{1'b1, 1'b0, 32'h0000_0900, 32'h0, 4'hF, 7}, 1'b0);
    resp_en = 1'b1;
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
